// File: rtl/btb_sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_sat_pkg
// Description : Shared types and default sizing for the saturating-counter BTB.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_sat_pkg;

    localparam int unsigned BTB_ENTRIES             = 8;
    localparam int unsigned BITS_SATURATION_COUNTER = 2;
    localparam int unsigned BTB_TAG_BITS            = 8;

    // Resolved branch from EX
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        is_lower_16;
        logic        clear;
        logic        valid;
    } branchpredict;

    // Prediction handed to the scoreboard/fetch
    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        is_lower_16;
    } branchpredict_sbe;

    typedef struct packed {
        logic                               valid;
        logic [BTB_TAG_BITS-1:0]            tag;
        logic [63:0]                        target;
        logic                               is_lower_16;
        logic [BITS_SATURATION_COUNTER-1:0] cnt;
    } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/btb_sat_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Loadable up/down counter that saturates at 0 and all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import btb_sat_pkg::*;
#(
    parameter int unsigned      WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RESET_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/btb_sat.sv
`default_nettype none
// ============================================================================
// Module      : btb_sat
// Description : Partial-tag branch target buffer with per-entry saturating
//               direction counters, per-entry clear and global flush.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_sat
    import btb_sat_pkg::*;
#(
    parameter int unsigned NR_ENTRIES              = BTB_ENTRIES,
    parameter int unsigned BITS_SATURATION_COUNTER = btb_sat_pkg::BITS_SATURATION_COUNTER,
    parameter int unsigned TAG_BITS                = BTB_TAG_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [63:0]      vpc_i,
    input  branchpredict     branch_predict_i,
    output branchpredict_sbe branch_predict_o
);

    localparam int unsigned c_IDX     = $clog2(NR_ENTRIES);
    localparam int unsigned c_TW      = (TAG_BITS > 0) ? TAG_BITS : 1;
    localparam int unsigned c_N       = BITS_SATURATION_COUNTER;
    localparam int unsigned c_WT_INT  = 1 << (c_N - 1);
    localparam int unsigned c_WNT_INT = c_WT_INT - 1;
    localparam logic [c_N-1:0] c_WT   = c_WT_INT[c_N-1:0];
    localparam logic [c_N-1:0] c_WNT  = c_WNT_INT[c_N-1:0];

    logic [NR_ENTRIES-1:0] w_valid;
    logic [NR_ENTRIES-1:0] w_lower;
    logic [c_TW-1:0]       w_tag    [NR_ENTRIES];
    logic [63:0]           w_target [NR_ENTRIES];
    logic [c_N-1:0]        w_cnt    [NR_ENTRIES];

    logic [63:0]      w_lk_sh;
    logic [63:0]      w_up_sh;
    logic [c_IDX-1:0] w_lk_idx;
    logic [c_IDX-1:0] w_up_idx;
    logic [c_TW-1:0]  w_lk_tag;
    logic [c_TW-1:0]  w_up_tag;
    logic             w_lk_hit;
    logic             w_up_hit;
    logic             w_up_en;
    logic             w_unused_bits;

    // Bit 0 is dropped from the index since compressed code is halfword aligned
    assign w_lk_idx = vpc_i[c_IDX:1];
    assign w_up_idx = branch_predict_i.pc[c_IDX:1];
    assign w_lk_sh  = vpc_i >> (c_IDX + 1);
    assign w_up_sh  = branch_predict_i.pc >> (c_IDX + 1);
    assign w_lk_tag = (TAG_BITS == 0) ? '0 : w_lk_sh[c_TW-1:0];
    assign w_up_tag = (TAG_BITS == 0) ? '0 : w_up_sh[c_TW-1:0];

    assign w_lk_hit = w_valid[w_lk_idx] & (w_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = w_valid[w_up_idx] & (w_tag[w_up_idx] == w_up_tag);
    assign w_up_en  = branch_predict_i.valid & ~flush_i;

    assign w_unused_bits = ^{vpc_i, branch_predict_i, w_lk_sh, w_up_sh};

    always_comb begin
        branch_predict_o                 = '0;
        branch_predict_o.valid           = w_lk_hit;
        branch_predict_o.predict_taken   = w_lk_hit & w_cnt[w_lk_idx][c_N-1];
        branch_predict_o.predict_address = w_target[w_lk_idx];
        branch_predict_o.is_lower_16     = w_lower[w_lk_idx];
    end

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
        localparam logic [c_IDX-1:0] c_ME = c_IDX'(gi);

        logic            w_sel;
        logic            w_train;
        logic            w_alloc;
        logic            w_drop;
        logic            r_valid;
        logic            r_lower;
        logic [c_TW-1:0] r_tag;
        logic [63:0]     r_target;

        assign w_sel   = w_up_en & (w_up_idx == c_ME);
        assign w_drop  = w_sel &  branch_predict_i.clear &  w_up_hit;
        assign w_train = w_sel & ~branch_predict_i.clear &  w_up_hit;
        // A clear that misses the tag leaves the entry alone rather than allocating
        assign w_alloc = w_sel & ~branch_predict_i.clear & ~w_up_hit;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
                r_lower  <= 1'b0;
            end else if (flush_i || w_drop) begin
                r_valid  <= 1'b0;
            end else if (w_alloc) begin
                r_valid  <= 1'b1;
                r_tag    <= w_up_tag;
                r_target <= branch_predict_i.target_address;
                r_lower  <= branch_predict_i.is_lower_16;
            end else if (w_train && branch_predict_i.is_taken) begin
                r_target <= branch_predict_i.target_address;
                r_lower  <= branch_predict_i.is_lower_16;
            end
        end

        sat_counter #(
            .WIDTH     (c_N),
            .RESET_VAL (c_WNT)
        ) u_cnt (
            .clk        (clk_i),
            .rst        (rst_i),
            .i_inc      (w_train &  branch_predict_i.is_taken),
            .i_dec      (w_train & ~branch_predict_i.is_taken),
            .i_load     (w_alloc),
            .i_load_val (branch_predict_i.is_taken ? c_WT : c_WNT),
            .o_cnt      (w_cnt[gi])
        );

        assign w_valid[gi]  = r_valid;
        assign w_lower[gi]  = r_lower;
        assign w_tag[gi]    = r_tag;
        assign w_target[gi] = r_target;
    end

endmodule
`default_nettype wire
